serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// and reports sum, carry-out and signed overflow after N cycles.
module serial_adder #(
    parameter int unsigned N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    input  logic         SUB,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] S,
    output logic         COUT,
    output logic         V
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [CW-1:0] cnt;
    logic          sum_bit;
    logic          carry_bit;

    // COUT doubles as the running carry register; it is final once RUN ends.
    assign sum_bit   = a_q[0] ^ b_q[0] ^ COUT;
    assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & COUT) | (b_q[0] & COUT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            S     <= '0;
            COUT  <= 1'b0;
            V     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        a_q   <= A;
                        b_q   <= SUB ? ~B : B;
                        COUT  <= SUB ? 1'b1 : CIN;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q  <= a_q >> 1;
                    b_q  <= b_q >> 1;
                    COUT <= carry_bit;
                    S    <= {sum_bit, S[N-1:1]};
                    cnt  <= cnt + CW'(1);
                    // On the MSB, COUT still holds the carry into it.
                    if (cnt == CW'(N - 1)) begin
                        V     <= COUT ^ carry_bit;
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8): directed cases plus random
// operations checked against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned N = 8;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic         SUB;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] S;
    logic         COUT;
    logic         V;

    int tests = 0;
    int fails = 0;

    serial_adder #(.N(N)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .A    (A),
        .B    (B),
        .CIN  (CIN),
        .SUB  (SUB),
        .BUSY (BUSY),
        .DONE (DONE),
        .S    (S),
        .COUT (COUT),
        .V    (V)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub,
                                  output logic [7:0] s, output logic c, output logic v);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        int sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + int'(cin);
            c  = (r > 255);
            sr = sa + sb + int'(cin);
        end
        s = 8'(r);
        v = (sr > 127) || (sr < -128);
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // One complete operation from an idle DUT, with latency/busy/hold checks.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input string tag);
        logic [7:0] es;
        logic       ec;
        logic       ev;
        int         lat;
        int         busy_n;
        int         overlap;
        bit         seen;
        model(a, b, cin, sub, es, ec, ev);
        A = a; B = b; CIN = cin; SUB = sub; START = 1'b1;
        tick();
        START = 1'b0;
        A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom); SUB = 1'($urandom);
        busy_n  = BUSY ? 1 : 0;
        overlap = 0;
        lat     = 0;
        seen    = 0;
        while (!seen && lat < 3 * N) begin
            tick();
            lat++;
            if (BUSY && DONE) overlap++;
            if (DONE) seen = 1;
            else if (BUSY) busy_n++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N + 1));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(N));
        check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check({tag, " S"}, 32'(S), 32'(es));
        check({tag, " COUT"}, 32'(COUT), 32'(ec));
        check({tag, " V"}, 32'(V), 32'(ev));
        tick();
        check({tag, " done_one_cycle"}, 32'(DONE), 32'd0);
        check({tag, " S_hold"}, 32'(S), 32'(es));
    endtask

    initial begin
        int t;
        int nd;
        int last;
        int lat;
        int dcount;
        bit seen;

        // Reset with START asserted: reset must win.
        RST = 1'b1; START = 1'b1; A = 8'h5A; B = 8'h3C; CIN = 1'b1; SUB = 1'b0;
        tick();
        tick();
        check("rst BUSY", 32'(BUSY), 32'd0);
        check("rst DONE", 32'(DONE), 32'd0);
        check("rst S", 32'(S), 32'd0);
        check("rst COUT", 32'(COUT), 32'd0);
        check("rst V", 32'(V), 32'd0);
        RST = 1'b0; START = 1'b0;
        tick();
        check("idle after rst BUSY", 32'(BUSY), 32'd0);

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        do_op(8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20");
        do_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
        do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub_cin_ignored");
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_pos_ovf");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");

        // START held high: one operation every N+2 cycles.
        A = 8'hFF; B = 8'hFF; CIN = 1'b1; SUB = 1'b0; START = 1'b1;
        t = 0; nd = 0; last = -1;
        while (nd < 3 && t < 60) begin
            tick();
            t++;
            if (DONE) begin
                nd++;
                check("b2b S", 32'(S), 32'h0000_00FF);
                check("b2b COUT", 32'(COUT), 32'd1);
                check("b2b V", 32'(V), 32'd0);
                if (last >= 0) check("b2b spacing", 32'(t - last), 32'(N + 2));
                else check("b2b first_done", 32'(t), 32'(N + 2));
                last = t;
            end
        end
        START = 1'b0;
        check("b2b done_count", 32'(nd), 32'd3);
        tick();
        check("b2b stopped BUSY", 32'(BUSY), 32'd0);

        // START during RUN must be ignored.
        A = 8'h01; B = 8'h01; CIN = 1'b0; SUB = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        START = 1'b1; A = 8'hAA; B = 8'h55;
        tick();
        START = 1'b0;
        lat = 4; seen = 0;
        while (!seen && lat < 3 * N) begin
            tick();
            lat++;
            if (DONE) seen = 1;
        end
        check("ign_start latency", 32'(lat), 32'(N + 1));
        check("ign_start S", 32'(S), 32'h0000_0002);
        check("ign_start COUT", 32'(COUT), 32'd0);
        check("ign_start V", 32'(V), 32'd0);
        tick();
        check("ign_start no_reaccept BUSY", 32'(BUSY), 32'd0);

        // Reset on RUN edge 3 aborts without a DONE pulse.
        A = 8'h5A; B = 8'h3C; CIN = 1'b0; SUB = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort BUSY", 32'(BUSY), 32'd0);
        check("abort S", 32'(S), 32'd0);
        check("abort DONE", 32'(DONE), 32'd0);
        check("abort COUT", 32'(COUT), 32'd0);
        dcount = 0;
        repeat (2 * N + 4) begin
            tick();
            if (DONE || BUSY) dcount++;
        end
        check("abort no_done", 32'(dcount), 32'd0);
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, "post_abort");

        for (int i = 0; i < 40; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
